// File: rtl/axi4_write_master.sv
// rtl/axi4_write_master.sv - AXI4-lite single-beat store master with lane alignment
// Optional B-response timeout enabled by defining AXI_WMASTER_TIMEOUT_EN.
module axi4_write_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [1:0]  req_size,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        done_timeout,
    output logic [63:0] AW_ADDR,
    output logic        AW_VALID,
    input  logic        AW_READY,
    output logic [63:0] W_DATA,
    output logic [7:0]  W_STRB,
    output logic        W_VALID,
    input  logic        W_READY,
    input  logic [1:0]  B_RESP,
    input  logic        B_VALID,
    output logic        B_READY
);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_B, DONE} state_t;

    state_t      state;
    logic [2:0]  off;
    logic [7:0]  strb_base;
    logic        misaligned;
    logic        aw_fin;
    logic        w_fin;

    always_comb begin
        off        = req_addr[2:0];
        strb_base  = 8'h01;
        misaligned = 1'b0;
        case (req_size)
            2'd0: begin strb_base = 8'h01; misaligned = 1'b0;       end
            2'd1: begin strb_base = 8'h03; misaligned = off[0];     end
            2'd2: begin strb_base = 8'h0F; misaligned = |off[1:0];  end
            default: begin strb_base = 8'hFF; misaligned = |off;    end
        endcase
    end

    assign req_ready = (state == IDLE);
    // A channel counts as finished once its VALID has dropped or it handshakes now.
    assign aw_fin    = !AW_VALID || AW_READY;
    assign w_fin     = !W_VALID || W_READY;

`ifdef AXI_WMASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        expire;

    // Firing at TIMEOUT_CYCLES-2 lands the done pulse TIMEOUT_CYCLES cycles after accept.
    assign expire = (tmo_cnt == 16'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 16'd0;
        end else if (state == IDLE && req_valid) begin
            tmo_cnt <= 16'd0;
        end else if (state == XFER || state == WAIT_B) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign done_timeout = 1'b0;
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            AW_ADDR   <= 64'd0;
            AW_VALID  <= 1'b0;
            W_DATA    <= 64'd0;
            W_STRB    <= 8'd0;
            W_VALID   <= 1'b0;
            B_READY   <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
`ifdef AXI_WMASTER_TIMEOUT_EN
            done_timeout <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AXI_WMASTER_TIMEOUT_EN
            done_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        AW_ADDR <= req_addr;
                        W_DATA  <= req_data << {off, 3'b000};
                        W_STRB  <= strb_base << off;
                        if (misaligned) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            done_resp <= 2'b10;
                        end else begin
                            state    <= XFER;
                            AW_VALID <= 1'b1;
                            W_VALID  <= 1'b1;
                        end
                    end
                end
                XFER: begin
`ifdef AXI_WMASTER_TIMEOUT_EN
                    if (expire) begin
                        AW_VALID     <= 1'b0;
                        W_VALID      <= 1'b0;
                        state        <= DONE;
                        done         <= 1'b1;
                        done_resp    <= 2'b10;
                        done_timeout <= 1'b1;
                    end else
`endif
                    begin
                        if (AW_VALID && AW_READY) AW_VALID <= 1'b0;
                        if (W_VALID && W_READY)   W_VALID  <= 1'b0;
                        if (aw_fin && w_fin) begin
                            state   <= WAIT_B;
                            B_READY <= 1'b1;
                        end
                    end
                end
                WAIT_B: begin
                    if (B_VALID) begin
                        B_READY   <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                        done_resp <= B_RESP;
                    end
`ifdef AXI_WMASTER_TIMEOUT_EN
                    else if (expire) begin
                        B_READY      <= 1'b0;
                        state        <= DONE;
                        done         <= 1'b1;
                        done_resp    <= 2'b10;
                        done_timeout <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_write_master.sv
// tb/tb_axi4_write_master.sv - directed vector bench for axi4_write_master
module tb_axi4_write_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_data = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        done;
    logic [1:0]  done_resp;
    logic        done_timeout;
    logic [63:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY = 1'b0;
    logic [63:0] W_DATA;
    logic [7:0]  W_STRB;
    logic        W_VALID;
    logic        W_READY = 1'b0;
    logic [1:0]  B_RESP = 2'b00;
    logic        B_VALID = 1'b0;
    logic        B_READY;

    always #5 clk = ~clk;

    axi4_write_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(done), .done_resp(done_resp), .done_timeout(done_timeout),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [1:0]  bresp;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          done_cyc;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[8];

    // Slave always ready; cycle 0 is the accept cycle, outputs sampled on the falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        int done_cyc = -1;
        int done_cnt = 0;
        int aw_cyc = 0;
        int w_cyc = 0;
        int bready_cyc = -1;
        logic [1:0] resp = 2'b00;
        logic tmo = 1'b0;
        @(negedge clk);
        check({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_size = v.size;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = v.bresp;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (AW_VALID) begin
                aw_cyc++;
                check({tag, ".aw_addr"}, AW_ADDR, v.addr);
            end
            if (W_VALID) begin
                w_cyc++;
                check({tag, ".w_data"}, W_DATA, v.wdata);
                check({tag, ".w_strb"}, 64'(W_STRB), 64'(v.strb));
            end
            if (B_READY && bready_cyc < 0) bready_cyc = c;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; resp = done_resp; tmo = done_timeout; end
            end
        end
        B_VALID = 1'b0;
        check({tag, ".done_cycle"}, 64'(done_cyc), 64'(v.done_cyc));
        check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
        check({tag, ".done_resp"}, 64'(resp), 64'(v.resp));
        check({tag, ".done_timeout"}, 64'(tmo), 64'd0);
        check({tag, ".aw_cycles"}, 64'(aw_cyc), (v.done_cyc == 1) ? 64'd0 : 64'd1);
        check({tag, ".w_cycles"}, 64'(w_cyc), (v.done_cyc == 1) ? 64'd0 : 64'd1);
        check({tag, ".b_ready_cycle"}, 64'(bready_cyc), (v.done_cyc == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd2);
    endtask

    initial begin
        vecs[0] = '{64'h8000_0000, 64'h1122_3344_5566_7788, 2'd3, 2'b00, 8'hFF, 64'h1122_3344_5566_7788, 3, 2'b00};
        vecs[1] = '{64'h8000_0005, 64'h0000_0000_0000_00AB, 2'd0, 2'b00, 8'h20, 64'h0000_AB00_0000_0000, 3, 2'b00};
        vecs[2] = '{64'h8000_0002, 64'h0000_0000_0000_BEEF, 2'd1, 2'b00, 8'h0C, 64'h0000_0000_BEEF_0000, 3, 2'b00};
        vecs[3] = '{64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 2'd2, 2'b00, 8'hF0, 64'hDEAD_BEEF_0000_0000, 3, 2'b00};
        vecs[4] = '{64'h8000_0003, 64'h0000_0000_0000_1234, 2'd1, 2'b00, 8'h00, 64'h0, 1, 2'b10};
        vecs[5] = '{64'h8000_0006, 64'h0000_0000_0000_5678, 2'd2, 2'b00, 8'h00, 64'h0, 1, 2'b10};
        vecs[6] = '{64'h8000_0010, 64'h0000_0000_0000_CAFE, 2'd3, 2'b10, 8'hFF, 64'h0000_0000_0000_CAFE, 3, 2'b10};
        vecs[7] = '{64'h8000_0007, 64'h0000_0000_0000_005A, 2'd0, 2'b11, 8'h80, 64'h5A00_0000_0000_0000, 3, 2'b11};

        #12;
        check("rst.aw_valid", 64'(AW_VALID), 64'd0);
        check("rst.w_valid", 64'(W_VALID), 64'd0);
        check("rst.b_ready", 64'(B_READY), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.done_timeout", 64'(done_timeout), 64'd0);
        check("rst.done_resp", 64'(done_resp), 64'd0);
        check("rst.aw_addr", AW_ADDR, 64'd0);
        check("rst.w_data", W_DATA, 64'd0);
        check("rst.w_strb", 64'(W_STRB), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Skewed readies: W at cycle 1, AW at cycle 4, B offered from cycle 5.
        begin
            int w_low = -1, aw_low = -1, br = -1, dc = -1, dn = 0;
            @(negedge clk);
            req_valid = 1'b1; req_addr = 64'h8000_0020; req_data = 64'h0123_4567_89AB_CDEF; req_size = 2'd3;
            AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b00;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (!W_VALID && w_low < 0) w_low = c;
                if (!AW_VALID && aw_low < 0) aw_low = c;
                if (B_READY && br < 0) br = c;
                if (done) begin dn++; if (dc < 0) dc = c; end
                W_READY  = (c == 1);
                AW_READY = (c == 4);
                B_VALID  = (c >= 5);
            end
            B_VALID = 1'b0;
            check("skew.w_valid_low", 64'(w_low), 64'd2);
            check("skew.aw_valid_low", 64'(aw_low), 64'd5);
            check("skew.b_ready", 64'(br), 64'd5);
            check("skew.done_cycle", 64'(dc), 64'd6);
            check("skew.done_count", 64'(dn), 64'd1);
        end

        // Reset while AW/W are outstanding.
        begin
            int dn = 0;
            @(negedge clk);
            req_valid = 1'b1; req_addr = 64'h8000_0040; req_data = 64'h55; req_size = 2'd3;
            AW_READY = 1'b0; W_READY = 1'b0;
            @(negedge clk);
            req_valid = 1'b0;
            check("rstmid.aw_valid_before", 64'(AW_VALID), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            check("rstmid.aw_valid", 64'(AW_VALID), 64'd0);
            check("rstmid.w_valid", 64'(W_VALID), 64'd0);
            check("rstmid.b_ready", 64'(B_READY), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done) dn++;
            end
            check("rstmid.no_done", 64'(dn), 64'd0);
            check("rstmid.req_ready", 64'(req_ready), 64'd1);
            run_vec(vecs[0], "rstmid.after");
        end

`ifdef AXI_WMASTER_TIMEOUT_EN
        begin
            int dc = -1, dn = 0;
            logic [1:0] rs = 2'b00;
            logic tf = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_addr = 64'h8000_0080; req_data = 64'h77; req_size = 2'd3;
            AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (done) begin
                    dn++;
                    if (dc < 0) begin dc = c; rs = done_resp; tf = done_timeout; end
                end
            end
            check("tmo.done_cycle", 64'(dc), 64'(TO));
            check("tmo.done_count", 64'(dn), 64'd1);
            check("tmo.done_resp", 64'(rs), 64'd2);
            check("tmo.done_timeout", 64'(tf), 64'd1);
            check("tmo.b_ready_low", 64'(B_READY), 64'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_write_master.md
# axi4_write_master

Store-side AXI4-lite write master: accepts one store request at a time from the LSU and converts it into an AXI4-lite write. Aligns data and byte strobes to the 64-bit bus, drives the AW and W channels concurrently, collects the B response, and returns a single-cycle completion to the LSU. It sits directly upstream of the AXI4-lite write slave and drives that slave's AW, W and B channels.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed between request accept and B handshake. Only used with AXI_WMASTER_TIMEOUT_EN. Range 2..65535.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  LSU store request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  64  byte address
- req_data  in  64  store data, right-aligned (LSB = first byte)
- req_size  in  2  0/1/2/3 = 1/2/4/8 bytes
- done  out  1  one-cycle completion pulse
- done_resp  out  2  BRESP captured, or 2'b10 on local error; valid when done=1
- done_timeout  out  1  with done: completion caused by timeout (always 0 without macro)
- AW_ADDR  out  64  write address
- AW_VALID  out  1
- AW_READY  in  1
- W_DATA  out  64  lane-aligned data
- W_STRB  out  8  byte strobes
- W_VALID  out  1
- W_READY  in  1
- B_RESP  in  2  slave response
- B_VALID  in  1
- B_READY  out  1

## Operation
- States: IDLE, XFER (AW and/or W outstanding), WAIT_B, DONE.
- IDLE: req_ready=1. Accept on req_valid & req_ready. Register addr, size, aligned data and strobe.
- Alignment: off = req_addr[2:0]; nbytes = 1<<req_size; W_STRB = ((1<<nbytes)-1) << off, truncated to 8 bits; W_DATA = req_data << (8*off). AW_ADDR = req_addr unmodified.
- Misalignment: off not a multiple of nbytes. On accept, go straight to DONE with done_resp=2'b10, no AW/W activity.
- XFER: AW_VALID and W_VALID both assert on the cycle after accept. Each drops on the cycle after its own handshake (VALID&READY); the other stays up. AW_ADDR, W_DATA and W_STRB hold stable while their VALID is high. VALID never depends on READY.
- XFER -> WAIT_B once both handshakes are done. Both may complete in the same cycle, or in either order.
- WAIT_B: B_READY=1. On B_VALID, capture B_RESP and go to DONE. B_VALID arriving before B_READY is held pending by the slave and is not lost.
- DONE: done=1 for exactly one cycle with done_resp. Return to IDLE. req_ready=0 in DONE, so back-to-back requests are spaced at least one cycle apart.

## Timing
- Reset (async, immediate): state=IDLE. AW_VALID, W_VALID, B_READY, done, done_timeout = 0. done_resp=2'b00. AW_ADDR, W_DATA, W_STRB = 0. req_ready=1 after reset.
- Minimum latency with the slave always ready: accept at cycle 0, AW/W handshake at cycle 1, B_READY at cycle 2, B handshake at cycle 2, done at cycle 3.
- Misaligned request: accept at cycle 0, done at cycle 1.
- Reset asserted mid-transfer: VALIDs and B_READY drop combinationally with reset. The transaction is abandoned and no done is issued.
- All outputs are registered except req_ready, which decodes state.

## Configuration
- AXI_WMASTER_TIMEOUT_EN defined: a 16-bit counter clears on accept and increments in XFER and WAIT_B.
  - When it reaches TIMEOUT_CYCLES, force AW_VALID, W_VALID and B_READY to 0 and go to DONE with done_resp=2'b10 and done_timeout=1.
  - A B handshake in the same cycle as expiry wins: normal completion, done_timeout=0.
- Not defined: no counter. done_timeout is tied 0 and the master waits indefinitely.

## Test plan
- Aligned doubleword: addr 0x8000_0000, data 0x1122334455667788, size 3, slave always ready -> W_STRB=0xFF, W_DATA unchanged, done at cycle 3, done_resp=2'b00.
- Byte at offset 5: addr 0x8000_0005, data 0xAB, size 0 -> W_STRB=0x20, W_DATA=0x0000AB0000000000.
- Skewed readies: AW_READY at cycle 4, W_READY at cycle 1 -> W_VALID low from cycle 2, AW_VALID low from cycle 5, B_READY from cycle 5, one done pulse.
- Misaligned halfword: addr 0x...03, size 1 -> no AW_VALID/W_VALID, done at cycle 1 with resp 2'b10. A slave B_RESP=2'b10 on a normal write is forwarded as done_resp=2'b10.
- Reset mid-operation: assert rst_n=0 while AW_VALID=1 -> AW_VALID, W_VALID=0 immediately, no done. After release, req_ready=1 and the next write completes normally.
- With AXI_WMASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, B_VALID never asserted -> done, done_timeout=1, done_resp=2'b10 exactly 16 cycles after accept.
